// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - scratchpad command word types and packing helpers
package datapath_pkg;

  localparam int SPAD_CMD_W = 38;

  typedef enum logic [1:0] {
    SPAD_LOAD  = 2'b01,
    SPAD_STORE = 2'b10,
    SPAD_GEMM  = 2'b11
  } spad_op_t;

  typedef struct packed {
    spad_op_t    op;
    logic [3:0]  rd;
    logic [31:0] payload;
  } spad_cmd_t;

  typedef enum logic {
    GNT_MLS  = 1'b0,
    GNT_GEMM = 1'b1
  } gnt_src_t;

  function automatic logic is_mls_op(input logic [1:0] ls);
    return (ls == SPAD_LOAD) || (ls == SPAD_STORE);
  endfunction

  function automatic spad_cmd_t pack_mls(input logic [1:0] ls, input logic [3:0] rd,
                                         input logic [31:0] addr);
    spad_cmd_t c;
    c.op      = spad_op_t'(ls);
    c.rd      = rd;
    c.payload = addr;
    return c;
  endfunction

  // GEMM reuses the rd field for the weight flags; the select sits in the low payload half
  function automatic spad_cmd_t pack_gemm(input logic [3:0] wflags, input logic [15:0] sel);
    spad_cmd_t c;
    c.op      = SPAD_GEMM;
    c.rd      = wflags;
    c.payload = {16'd0, sel};
    return c;
  endfunction

endpackage

// File: rtl/spad_cmd_fifo.sv
// rtl/spad_cmd_fifo.sv - first-word-fall-through synchronous FIFO with flush
module spad_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 38,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign w_push    = i_wr_en && !o_full && !i_flush;
  assign w_pop     = i_rd_en && !o_empty && !i_flush;
  assign o_rd_data = o_empty ? '0 : r_mem[r_head];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_tail] <= i_wr_data;
  end

endmodule

// File: rtl/spad_req_queue.sv
// rtl/spad_req_queue.sv - MLS/GEMM request arbiter and command queue to the scratchpad
// Optional SPAD_REQ_PERF_EN adds stall_cycles and enq_count counters.
module spad_req_queue
  import datapath_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  mls_valid,
  input  logic [1:0]            mls_ls,
  input  logic [3:0]            mls_rd,
  input  logic [31:0]           mls_addr,
  output logic                  mls_ready,
  input  logic                  gemm_valid,
  input  logic [3:0]            gemm_wflags,
  input  logic [15:0]           gemm_sel,
  output logic                  gemm_ready,
  input  logic                  spad_ren,
  output logic [SPAD_CMD_W-1:0] spad_rdata,
  output logic                  spad_empty,
  output logic                  spad_full,
  output logic [CNT_W-1:0]      occupancy
`ifdef SPAD_REQ_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           enq_count
`endif
);

  gnt_src_t  r_last_gnt;
  logic      w_mls_req;
  logic      w_gemm_req;
  logic      w_can_enq;
  logic      w_grant_mls;
  logic      w_grant_gemm;
  logic      w_enq;
  spad_cmd_t w_cmd;

  assign w_mls_req    = mls_valid && is_mls_op(mls_ls);
  assign w_gemm_req   = gemm_valid;
  assign w_can_enq    = !RST && !flush && !spad_full;
  assign w_grant_mls  = w_can_enq && w_mls_req && (!w_gemm_req || (r_last_gnt == GNT_GEMM));
  assign w_grant_gemm = w_can_enq && w_gemm_req && !w_grant_mls;
  assign w_enq        = w_grant_mls || w_grant_gemm;
  assign w_cmd        = w_grant_mls ? pack_mls(mls_ls, mls_rd, mls_addr)
                                    : pack_gemm(gemm_wflags, gemm_sel);

  // Readies are the grant itself, so the pop request never reaches them
  assign mls_ready  = w_grant_mls;
  assign gemm_ready = w_grant_gemm;

  always_ff @(posedge CLK) begin
    if (RST)               r_last_gnt <= GNT_GEMM;
    else if (w_grant_mls)  r_last_gnt <= GNT_MLS;
    else if (w_grant_gemm) r_last_gnt <= GNT_GEMM;
  end

  spad_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SPAD_CMD_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_flush   (flush),
    .i_wr_en   (w_enq),
    .i_wr_data (w_cmd),
    .i_rd_en   (spad_ren),
    .o_rd_data (spad_rdata),
    .o_empty   (spad_empty),
    .o_full    (spad_full),
    .o_count   (occupancy)
  );

`ifdef SPAD_REQ_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_enq_count;
  logic        w_stall;

  assign w_stall = (w_mls_req && !w_grant_mls) || (w_gemm_req && !w_grant_gemm);

  // Counters survive flush and saturate instead of wrapping
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cycles <= '0;
      r_enq_count    <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_enq && (r_enq_count != '1))      r_enq_count    <= r_enq_count + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign enq_count    = r_enq_count;
`endif

endmodule

// File: tb/tb_spad_req_queue.sv
// tb/tb_spad_req_queue.sv - self-checking bench for spad_req_queue
module tb_spad_req_queue;
  import datapath_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic        CLK = 1'b0;
  logic        RST, flush;
  logic        mls_valid, mls_ready, gemm_valid, gemm_ready;
  logic [1:0]  mls_ls;
  logic [3:0]  mls_rd, gemm_wflags;
  logic [31:0] mls_addr;
  logic [15:0] gemm_sel;
  logic        spad_ren, spad_empty, spad_full;
  logic [37:0] spad_rdata;
  logic [CNT_W-1:0] occupancy;
`ifdef SPAD_REQ_PERF_EN
  logic [31:0] stall_cycles, enq_count;
  int unsigned m_stall, m_enq;
`endif

  always #5 CLK = ~CLK;

  spad_req_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .mls_valid(mls_valid), .mls_ls(mls_ls), .mls_rd(mls_rd), .mls_addr(mls_addr),
    .mls_ready(mls_ready),
    .gemm_valid(gemm_valid), .gemm_wflags(gemm_wflags), .gemm_sel(gemm_sel),
    .gemm_ready(gemm_ready),
    .spad_ren(spad_ren), .spad_rdata(spad_rdata), .spad_empty(spad_empty),
    .spad_full(spad_full), .occupancy(occupancy)
`ifdef SPAD_REQ_PERF_EN
    , .stall_cycles(stall_cycles), .enq_count(enq_count)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: an in-order queue of packed words plus who won the last grant
  logic [37:0] mq[$];
  bit          m_last_mls;
  bit          p_mreq, p_greq, p_egm, p_egg;

  typedef struct {
    logic        mv;
    logic [1:0]  ls;
    logic [3:0]  rd;
    logic [31:0] addr;
    logic        gv;
    logic [3:0]  wf;
    logic [15:0] sel;
    logic        ren;
    logic        mr;
    logic        gr;
    logic [37:0] rdata;
    int          occ;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic mv, input logic [1:0] ls, input logic [3:0] rd,
                              input logic [31:0] addr, input logic gv, input logic [3:0] wf,
                              input logic [15:0] sel, input logic ren, input logic mr,
                              input logic gr, input logic [37:0] rdata, input int occ);
    vec_t v;
    v.mv = mv; v.ls = ls; v.rd = rd; v.addr = addr; v.gv = gv; v.wf = wf; v.sel = sel;
    v.ren = ren; v.mr = mr; v.gr = gr; v.rdata = rdata; v.occ = occ;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic idle();
    RST = 1'b0; flush = 1'b0; mls_valid = 1'b0; mls_ls = 2'b01; mls_rd = 4'h0;
    mls_addr = 32'h0; gemm_valid = 1'b0; gemm_wflags = 4'h0; gemm_sel = 16'h0; spad_ren = 1'b0;
  endtask

  task automatic pre_edge(input string tag);
    bit can;
    #1;
    p_mreq = mls_valid && (mls_ls == 2'b01 || mls_ls == 2'b10);
    p_greq = gemm_valid;
    can    = !RST && !flush && (mq.size() < DEPTH);
    p_egm  = can && p_mreq && (!p_greq || !m_last_mls);
    p_egg  = can && p_greq && !p_egm;
    check({tag, " mls_ready"}, 64'(mls_ready), 64'(p_egm));
    check({tag, " gemm_ready"}, 64'(gemm_ready), 64'(p_egg));
  endtask

  task automatic model_update();
    if (RST) begin
      mq.delete();
      m_last_mls = 1'b0;
`ifdef SPAD_REQ_PERF_EN
      m_stall = 0; m_enq = 0;
`endif
    end else begin
`ifdef SPAD_REQ_PERF_EN
      if ((p_mreq && !p_egm) || (p_greq && !p_egg)) m_stall++;
      if (p_egm || p_egg) m_enq++;
`endif
      if (flush) mq.delete();
      else begin
        if (spad_ren && mq.size() > 0) void'(mq.pop_front());
        if (p_egm) begin mq.push_back({mls_ls, mls_rd, mls_addr}); m_last_mls = 1'b1; end
        if (p_egg) begin mq.push_back({2'b11, gemm_wflags, 16'h0, gemm_sel}); m_last_mls = 1'b0; end
      end
    end
  endtask

  task automatic post_edge(input string tag);
    logic [37:0] er;
    er = (mq.size() > 0) ? mq[0] : 38'h0;
    check({tag, " spad_rdata"}, 64'(spad_rdata), 64'(er));
    check({tag, " occupancy"}, 64'(occupancy), 64'(mq.size()));
    check({tag, " spad_empty"}, 64'(spad_empty), 64'(mq.size() == 0));
    check({tag, " spad_full"}, 64'(spad_full), 64'(mq.size() == DEPTH));
`ifdef SPAD_REQ_PERF_EN
    check({tag, " stall_cycles"}, 64'(stall_cycles), 64'(m_stall));
    check({tag, " enq_count"}, 64'(enq_count), 64'(m_enq));
`endif
  endtask

  task automatic step(input string tag);
    pre_edge(tag);
    @(posedge CLK);
    model_update();
    #1;
    post_edge(tag);
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 2'b01, 4'h3, 32'h1000_0040, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0,
                  {2'b01, 4'h3, 32'h1000_0040}, 1);
    vecs[1]  = mk(1'b0, 2'b01, 4'h0, 32'h0, 1'b1, 4'h8, 16'h00A5, 1'b1, 1'b0, 1'b1,
                  {2'b11, 4'h8, 16'h0, 16'h00A5}, 1);
    vecs[2]  = mk(1'b0, 2'b01, 4'h0, 32'h0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0, 38'h0, 0);
    vecs[3]  = mk(1'b1, 2'b00, 4'h5, 32'hDEAD_BEEF, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 38'h0, 0);
    vecs[4]  = mk(1'b1, 2'b11, 4'h6, 32'h1234_5678, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0, 38'h0, 0);
    vecs[5]  = mk(1'b1, 2'b10, 4'h1, 32'hA000_0001, 1'b1, 4'h2, 16'h1111, 1'b0, 1'b1, 1'b0,
                  {2'b10, 4'h1, 32'hA000_0001}, 1);
    vecs[6]  = mk(1'b1, 2'b10, 4'h2, 32'hA000_0002, 1'b1, 4'h2, 16'h2222, 1'b0, 1'b0, 1'b1,
                  {2'b10, 4'h1, 32'hA000_0001}, 2);
    vecs[7]  = mk(1'b1, 2'b01, 4'h3, 32'hA000_0003, 1'b1, 4'h3, 16'h3333, 1'b0, 1'b1, 1'b0,
                  {2'b10, 4'h1, 32'hA000_0001}, 3);
    vecs[8]  = mk(1'b1, 2'b01, 4'h4, 32'hA000_0004, 1'b1, 4'h4, 16'h4444, 1'b0, 1'b0, 1'b1,
                  {2'b10, 4'h1, 32'hA000_0001}, 4);
    vecs[9]  = mk(1'b0, 2'b01, 4'h0, 32'h0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0,
                  {2'b11, 4'h2, 16'h0, 16'h2222}, 3);
    vecs[10] = mk(1'b0, 2'b01, 4'h0, 32'h0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0,
                  {2'b01, 4'h3, 32'hA000_0003}, 2);
    vecs[11] = mk(1'b0, 2'b01, 4'h0, 32'h0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0,
                  {2'b11, 4'h4, 16'h0, 16'h4444}, 1);
    vecs[12] = mk(1'b0, 2'b01, 4'h0, 32'h0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0, 38'h0, 0);

    // Reset with both requesters active: readies must stay low
    idle();
    RST = 1'b1; mls_valid = 1'b1; gemm_valid = 1'b1;
    step("reset0");
    step("reset1");
    idle();

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      mls_valid = vecs[i].mv; mls_ls = vecs[i].ls; mls_rd = vecs[i].rd; mls_addr = vecs[i].addr;
      gemm_valid = vecs[i].gv; gemm_wflags = vecs[i].wf; gemm_sel = vecs[i].sel;
      spad_ren = vecs[i].ren;
      pre_edge(tag);
      check({tag, " tbl mls_ready"}, 64'(mls_ready), 64'(vecs[i].mr));
      check({tag, " tbl gemm_ready"}, 64'(gemm_ready), 64'(vecs[i].gr));
      @(posedge CLK);
      model_update();
      #1;
      post_edge(tag);
      check({tag, " tbl spad_rdata"}, 64'(spad_rdata), 64'(vecs[i].rdata));
      check({tag, " tbl occupancy"}, 64'(occupancy), 64'(vecs[i].occ));
    end

    // Fill to DEPTH, then pop and offer both requests while full
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      mls_valid = 1'b1; mls_ls = 2'b01; mls_rd = 4'(i); mls_addr = $urandom;
      step("fill");
    end
    check("full flag", 64'(spad_full), 64'(1));
    mls_valid = 1'b1; gemm_valid = 1'b1; spad_ren = 1'b1; mls_rd = 4'hF;
    step("full_pop");
    check("full_pop occupancy", 64'(occupancy), 64'(DEPTH - 1));
    idle(); mls_valid = 1'b1; mls_ls = 2'b10; mls_rd = 4'hE; mls_addr = 32'hCAFE_0001;
    step("reopen");
    check("reopen occupancy", 64'(occupancy), 64'(DEPTH));
    // Stalled requester while full
    step("stall0"); step("stall1"); step("stall2");
    idle(); spad_ren = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step("drain");

    // Flush with five entries and concurrent pop/request; last grant (MLS) survives it
    idle();
    for (int i = 0; i < 5; i++) begin
      mls_valid = 1'b1; mls_rd = 4'(i); mls_addr = $urandom;
      step("pre_flush");
    end
    flush = 1'b1; spad_ren = 1'b1;
    step("flush");
    check("flush spad_empty", 64'(spad_empty), 64'(1));
    idle(); mls_valid = 1'b1; gemm_valid = 1'b1; gemm_sel = 16'hBEEF;
    step("post_flush_tie");
    check("post_flush gemm_ready", 64'(p_egg), 64'(1));

    // Reset mid-operation restores the MLS-first tie break
    idle(); mls_valid = 1'b1; mls_addr = 32'h5555_0000;
    step("pre_rst0"); step("pre_rst1");
    RST = 1'b1; gemm_valid = 1'b1;
    step("mid_rst");
    idle(); mls_valid = 1'b1; gemm_valid = 1'b1; mls_addr = 32'h6666_0000;
    step("post_rst_tie");

    for (int c = 0; c < 600; c++) begin
      mls_valid   = ($urandom_range(0, 9) < 6);
      mls_ls      = 2'($urandom_range(0, 3));
      mls_rd      = 4'($urandom);
      mls_addr    = $urandom;
      gemm_valid  = 1'($urandom_range(0, 1));
      gemm_wflags = 4'($urandom);
      gemm_sel    = 16'($urandom);
      spad_ren    = ($urandom_range(0, 9) < ((c < 300) ? 3 : 7));
      flush       = ($urandom_range(0, 39) == 0);
      RST         = ($urandom_range(0, 99) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
